// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the JTAG serial word path (transmitter and receiver).
package serial_word_receiver_pkg;

   localparam int JTAG_WORD_WIDTH = 32;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

endpackage

// File: rtl/serial_word_receiver_shift_in_register.sv
// Serial-in parallel-out shifter, MSB first; word_done flags the edge that samples the last bit.
// Cannot stall: a completed word must be taken by the caller on that edge or it is lost.
module shift_in_register
   import serial_word_receiver_pkg::*;
#(
   parameter int WIDTH   = JTAG_WORD_WIDTH,
   parameter int COUNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               in,
   input  logic               clear,
   output logic [WIDTH-1:0]   word,
   output logic               word_done,
   output logic [COUNT_W-1:0] bit_count
);

   // Only WIDTH-1 bits need storing: the final bit arrives live on `in`.
   logic [WIDTH-2:0] shreg;

   assign word      = {shreg, in};
   assign word_done = enable && !clear && (bit_count == COUNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg     <= '0;
         bit_count <= '0;
      end else if (clear) begin
         shreg     <= '0;
         bit_count <= '0;
      end else if (enable) begin
         shreg     <= word[WIDTH-2:0];
         bit_count <= word_done ? '0 : bit_count + COUNT_W'(1);
      end
   end

endmodule

// File: rtl/serial_word_receiver.sv
// Deserializes MSB-first bits into WIDTH-bit words held in a one-word valid/ready register.
// Latency 1 cycle from last bit to out_valid; a word completing while the holder is full and not accepted is dropped and sets sticky overrun.
module serial_word_receiver
   import serial_word_receiver_pkg::*;
#(
   parameter int WIDTH   = JTAG_WORD_WIDTH,
   parameter int COUNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               in,
   input  logic               clear,
   output logic [WIDTH-1:0]   out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               overrun,
   output logic [COUNT_W-1:0] bit_count
);

   hold_state_t      state, state_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic             overrun_nxt;
   logic [WIDTH-1:0] word;
   logic             word_done;

   shift_in_register #(
      .WIDTH   (WIDTH),
      .COUNT_W (COUNT_W)
   ) u_shift (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .in        (in),
      .clear     (clear),
      .word      (word),
      .word_done (word_done),
      .bit_count (bit_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= HOLD_EMPTY;
         out     <= '0;
         overrun <= 1'b0;
      end else begin
         state   <= state_nxt;
         out     <= out_nxt;
         overrun <= overrun_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      out_nxt     = out;
      overrun_nxt = overrun;
      case (state)
         HOLD_EMPTY: begin
            if (word_done) begin
               out_nxt   = word;
               state_nxt = HOLD_FULL;
            end
         end
         HOLD_FULL: begin
            // Accept and refill on the same edge keeps the holder full without loss.
            if (word_done) begin
               if (out_ready) out_nxt = word;
               else           overrun_nxt = 1'b1;
            end else if (out_ready) begin
               state_nxt = HOLD_EMPTY;
            end
         end
         default: state_nxt = HOLD_EMPTY;
      endcase
      // word_done is already suppressed by clear, so this never races a new overrun.
      if (clear) overrun_nxt = 1'b0;
   end

   assign out_valid = (state == HOLD_FULL);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomized and directed bench for serial_word_receiver against a word-level reference model.
module tb_serial_word_receiver;

   localparam int W  = 32;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          in = 1'b0;
   logic          clear = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out;
   logic          out_valid;
   logic          overrun;
   logic [CW-1:0] bit_count;

   int total = 0;
   int bad   = 0;

   // reference model state: bits gathered so far, holder contents, sticky drop flag
   int           m_cnt;
   logic [31:0]  m_part;
   logic         m_valid;
   logic [31:0]  m_out;
   logic         m_ovr;

   serial_word_receiver dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .in        (in),
      .clear     (clear),
      .out       (out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .bit_count (bit_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_part  = 0;
      m_valid = 1'b0;
      m_out   = 0;
      m_ovr   = 1'b0;
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({ctx, ".out"},       out,            m_out);
      chk({ctx, ".overrun"},   32'(overrun),   32'(m_ovr));
      chk({ctx, ".bit_count"}, 32'(bit_count), 32'(m_cnt));
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic cycle(input logic en, input logic b, input logic clr, input logic rdy);
      logic        done;
      logic [31:0] word;
      enable    = en;
      in        = b;
      clear     = clr;
      out_ready = rdy;
      @(posedge clk);
      done = 1'b0;
      word = 0;
      if (clr) begin
         m_cnt  = 0;
         m_part = 0;
         m_ovr  = 1'b0;
      end else if (en) begin
         m_part = m_part * 2 + 32'(b);
         m_cnt  = m_cnt + 1;
         if (m_cnt == W) begin
            done   = 1'b1;
            word   = m_part;
            m_cnt  = 0;
            m_part = 0;
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_out   = word;
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      #1;
      check_all("cyc");
   endtask

   task automatic shift_word(input logic [31:0] w, input logic rdy_body, input logic rdy_last);
      for (int i = W - 1; i >= 0; i--)
         cycle(1'b1, w[i], 1'b0, (i == 0) ? rdy_last : rdy_body);
   endtask

   task automatic drain();
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [31:0] w;
      model_reset();

      // reset state
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;

      // basic word with consumer ready
      shift_word(32'hDEADBEEF, 1'b1, 1'b1);
      chk("deadbeef_out", out, 32'hDEADBEEF);
      chk("deadbeef_vld", 32'(out_valid), 32'd1);
      drain();

      // transmitter-style loopback pattern
      shift_word(32'hA5C30F96, 1'b1, 1'b1);
      chk("loopback_out", out, 32'hA5C30F96);
      drain();

      // back-to-back words while stalled: second is dropped
      shift_word(32'h00000001, 1'b0, 1'b0);
      shift_word(32'hFFFFFFFF, 1'b0, 1'b0);
      chk("ovr_out", out, 32'h00000001);
      chk("ovr_flag", 32'(overrun), 32'd1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovr_cleared", 32'(overrun), 32'd0);
      chk("ovr_vld_kept", 32'(out_valid), 32'd1);
      drain();

      // accept on the exact edge that completes the next word
      shift_word(32'h12345678, 1'b0, 1'b0);
      shift_word(32'h87654321, 1'b0, 1'b1);
      chk("refill_out", out, 32'h87654321);
      chk("refill_vld", 32'(out_valid), 32'd1);
      chk("refill_ovr", 32'(overrun), 32'd0);
      drain();

      // clear beats a simultaneous enable; next word has no stale bits
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      chk("clear_cnt", 32'(bit_count), 32'd0);
      shift_word(32'hCAFEF00D, 1'b0, 1'b0);
      chk("cafe_out", out, 32'hCAFEF00D);
      drain();

      // async reset mid-word with a held word
      shift_word(32'h0BADF00D, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      enable = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("arst_vld", 32'(out_valid), 32'd0);
      chk("arst_out", out, 32'd0);
      chk("arst_cnt", 32'(bit_count), 32'd0);
      chk("arst_ovr", 32'(overrun), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      shift_word(32'h5EED1234, 1'b0, 1'b0);
      chk("post_arst_out", out, 32'h5EED1234);
      drain();

      // random traffic
      for (int i = 0; i < 3000; i++)
         cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0 ? 1'b0 : 1'b1));
      for (int i = 0; i < 6; i++) begin
         w = $urandom;
         shift_word(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
